// File: rtl/shr_share_pkg.sv
// -----------------------------------------------------------------------------
// shr_share_pkg
// Shared definitions for the shared right-shifter controller:
//   - DEF_DATAWIDTH / DEF_NREQ : default operand width and requester count
//   - state_e                  : controller FSM state encoding
// -----------------------------------------------------------------------------
package shr_share_pkg;

  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_NREQ      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

endpackage : shr_share_pkg

// File: rtl/shr_share_shr.sv
// -----------------------------------------------------------------------------
// shr_share_shr
// Combinational logical right shifter (zero fill).
// Ports:
//   a_i      [DATAWIDTH-1:0]  operand
//   sh_amt_i [DATAWIDTH-1:0]  shift amount, full width is honoured
//   res_o    [DATAWIDTH-1:0]  a_i >> sh_amt_i
// -----------------------------------------------------------------------------
module shr_share_shr #(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] sh_amt_i,
  output logic [DATAWIDTH-1:0] res_o
);

  // The >> operator zero-fills and yields zero for any amount >= DATAWIDTH,
  // so oversized shift amounts need no special casing.
  assign res_o = a_i >> sh_amt_i;

endmodule : shr_share_shr

// File: rtl/shr_share_ctrl.sv
// -----------------------------------------------------------------------------
// shr_share_ctrl
// Round-robin arbiter sharing one right-shifter among NREQ requesters.
// A grant latches the winner's operands; the following cycle registers the
// shift result and pulses done for that requester.
// Ports:
//   Clk        clock (rising edge)
//   Rst        synchronous active-high reset
//   req        [NREQ-1:0]            per-requester request
//   a_in       [NREQ*DATAWIDTH-1:0]  operands, slice i = [i*DATAWIDTH +: DATAWIDTH]
//   sh_amt_in  [NREQ*DATAWIDTH-1:0]  shift amounts, sliced like a_in
//   gnt        [NREQ-1:0]            one-hot grant pulse
//   busy                             operation in flight
//   d_out      [DATAWIDTH-1:0]       registered shift result
//   done       [NREQ-1:0]            one-hot completion pulse (d_out valid)
// -----------------------------------------------------------------------------
module shr_share_ctrl
  import shr_share_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int NREQ      = DEF_NREQ
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_in,
  input  logic [NREQ*DATAWIDTH-1:0] sh_amt_in,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic [DATAWIDTH-1:0]      d_out,
  output logic [NREQ-1:0]           done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  // Unpacked views of the per-requester operand slices
  logic [DATAWIDTH-1:0] a_arr  [NREQ];
  logic [DATAWIDTH-1:0] sh_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign a_arr[gi]  = a_in[gi*DATAWIDTH +: DATAWIDTH];
      assign sh_arr[gi] = sh_amt_in[gi*DATAWIDTH +: DATAWIDTH];
    end
  endgenerate

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     win_q, win_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] sh_q, sh_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 busy_q, busy_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;

  logic [DATAWIDTH-1:0] shr_res;
  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;

  // Round-robin picker: scan from ptr upward with wrap. The scan runs from
  // the farthest candidate back to ptr so the nearest requester is the last
  // one written and therefore wins.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PTR_W'(idx);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  shr_share_shr #(
    .DATAWIDTH(DATAWIDTH)
  ) u_shr (
    .a_i     (a_q),
    .sh_amt_i(sh_q),
    .res_o   (shr_res)
  );

  // Next-state and output logic; gnt/done/busy default low so each is a
  // single-cycle pulse per operation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    a_d     = a_q;
    sh_d    = sh_q;
    gnt_d   = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          a_d     = a_arr[pick_idx];
          sh_d    = sh_arr[pick_idx];
          gnt_d   = ONE_HOT0 << pick_idx;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        dout_d  = shr_res;
        done_d  = ONE_HOT0 << win_q;
        ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      a_q     <= '0;
      sh_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      a_q     <= a_d;
      sh_q    <= sh_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign d_out = dout_q;

endmodule : shr_share_ctrl

// File: tb/tb_shr_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shr_share_ctrl
// Self-checking bench for shr_share_ctrl (DATAWIDTH=8, NREQ=4): directed
// vector table, hand-written multi-cycle sequences, then random operations
// against a behavioural round-robin / shift model.
// -----------------------------------------------------------------------------
module tb_shr_share_ctrl;

  localparam int DW = 8;
  localparam int NR = 4;

  logic             Clk;
  logic             Rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] a_in;
  logic [NR*DW-1:0] sh_amt_in;
  logic [NR-1:0]    gnt;
  logic             busy;
  logic [DW-1:0]    d_out;
  logic [NR-1:0]    done;

  int n_checks = 0;
  int n_fail   = 0;

  shr_share_ctrl #(
    .DATAWIDTH(DW),
    .NREQ     (NR)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .req      (req),
    .a_in     (a_in),
    .sh_amt_in(sh_amt_in),
    .gnt      (gnt),
    .busy     (busy),
    .d_out    (d_out),
    .done     (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] a;
    logic [NR*DW-1:0] sh;
    logic [NR-1:0]    exp_gnt;
    logic [DW-1:0]    exp_dout;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    req = '0;
    tick();
    Rst = 1'b0;
  endtask

  // One full operation: grant cycle, completion cycle, then a quiet cycle.
  // Inputs are scrambled after the grant to show the in-flight op ignores them.
  task automatic run_op(input logic [NR-1:0] r, input logic [NR*DW-1:0] a,
                        input logic [NR*DW-1:0] sh, input logic [NR-1:0] eg,
                        input logic [DW-1:0] ed);
    req = r; a_in = a; sh_amt_in = sh;
    tick();
    chk("gnt", gnt, eg);
    chk("busy_on_gnt", busy, 1);
    chk("done_on_gnt", done, 0);
    req = '0; a_in = ~a; sh_amt_in = ~sh;
    tick();
    chk("done", done, eg);
    chk("d_out", d_out, ed);
    chk("busy_on_done", busy, 0);
    chk("gnt_on_done", gnt, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("d_out_hold", d_out, ed);
    $display("op req=%b gnt_exp=%b d_out=%02h exp=%02h", r, eg, d_out, ed);
  endtask

  // Behavioural model state
  int            m_ptr;
  logic [DW-1:0] m_last;

  function automatic int model_pick(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < NR; k++) begin
      if (r[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_shift(input logic [DW-1:0] a, input int sh);
    if (sh >= DW) return '0;
    return DW'(int'(a) / (1 << sh));
  endfunction

  initial begin
    logic [NR*DW-1:0] ra, rsh;
    logic [NR-1:0]    rr;
    int               w;
    logic [DW-1:0]    ed;

    vecs[0] = '{4'b0001, 32'h33221114, 32'h05060701, 4'b0001, 8'h0A};
    vecs[1] = '{4'b0010, 32'h00002800, 32'h00000400, 4'b0010, 8'h02};
    vecs[2] = '{4'b0100, 32'h00AA0000, 32'h00080000, 4'b0100, 8'h00};
    vecs[3] = '{4'b1000, 32'hAA000000, 32'hC8000000, 4'b1000, 8'h00};
    vecs[4] = '{4'b0101, 32'h00110080, 32'h00000007, 4'b0001, 8'h01};
    vecs[5] = '{4'b0100, 32'h00550000, 32'h00020000, 4'b0100, 8'h15};
    vecs[6] = '{4'b0101, 32'h000900F0, 32'h00010004, 4'b0001, 8'h0F};
    vecs[7] = '{4'b1100, 32'hEEC30000, 32'h01030000, 4'b0100, 8'h18};
    vecs[8] = '{4'b0011, 32'h0000997E, 32'h00000201, 4'b0001, 8'h3F};

    // Reset with all requests high: no grant may issue in a reset cycle
    Rst = 1'b1; req = 4'b1111; a_in = '1; sh_amt_in = '0;
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dout", d_out, 0);
    Rst = 1'b0; req = '0;
    tick();
    chk("idle_gnt", gnt, 0);
    chk("idle_done", done, 0);

    // Directed table (ptr starts at 0 after reset)
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].req, vecs[i].a, vecs[i].sh, vecs[i].exp_gnt, vecs[i].exp_dout);

    // All four requesters held, each dropped on its grant
    do_reset();
    req = 4'b1111; a_in = 32'hFFFFFFFF; sh_amt_in = 32'h03020100;
    for (int i = 0; i < NR; i++) begin
      tick();
      chk("rr_gnt", gnt, 32'(1) << i);
      req[i] = 1'b0;
      tick();
      chk("rr_done", done, 32'(1) << i);
      chk("rr_dout", d_out, 32'(8'hFF >> i));
      chk("rr_gnt_gap", gnt, 0);
      $display("op rr i=%0d d_out=%02h", i, d_out);
    end
    tick();
    chk("rr_quiet", done, 0);

    // Reset during EXEC abandons the op and clears the pointer
    do_reset();
    run_op(4'b0001, 32'h00000064, 32'h00000002, 4'b0001, 8'h19);
    req = 4'b0100; a_in = 32'h00FF0000; sh_amt_in = '0;
    tick();
    chk("abort_gnt", gnt, 4'b0100);
    req = '0; Rst = 1'b1;
    tick();
    chk("abort_done", done, 0);
    chk("abort_dout", d_out, 0);
    chk("abort_busy", busy, 0);
    Rst = 1'b0;
    tick();
    chk("abort_no_late_done", done, 0);
    $display("op reset-in-exec d_out=%02h", d_out);
    run_op(4'b1010, 32'h00003C00, 32'h00000200, 4'b0010, 8'h0F);

    // Random operations against the model
    do_reset();
    m_ptr = 0; m_last = '0;
    for (int it = 0; it < 200; it++) begin
      rr = NR'($urandom_range(0, 15));
      ra = $urandom;
      for (int s = 0; s < NR; s++) begin
        if ($urandom_range(0, 7) == 0) rsh[s*DW +: DW] = DW'($urandom_range(8, 255));
        else                           rsh[s*DW +: DW] = DW'($urandom_range(0, 9));
      end
      w = model_pick(rr, m_ptr);
      if (w < 0) begin
        req = '0; a_in = ra; sh_amt_in = rsh;
        tick();
        chk("rnd_idle_gnt", gnt, 0);
        chk("rnd_idle_done", done, 0);
        chk("rnd_idle_dout", d_out, m_last);
        $display("op idle d_out=%02h", d_out);
      end else begin
        ed = model_shift(ra[w*DW +: DW], int'(rsh[w*DW +: DW]));
        run_op(rr, ra, rsh, NR'(1) << w, ed);
        m_ptr  = (w + 1) % NR;
        m_last = ed;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shr_share_ctrl

// File: doc/shr_share_ctrl.md
SHR_SHARE_CTRL -- requirements
Module: shr_share_ctrl

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the operand and result width.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing one right-shifter.
REQ-003 Clk  input  1  rising-edge clock, the only clock.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 req  input  NREQ  per-requester operation request, held high until granted.
REQ-006 a_in  input  NREQ*DATAWIDTH  operand per requester; slice i is bits [i*DATAWIDTH +: DATAWIDTH].
REQ-007 sh_amt_in  input  NREQ*DATAWIDTH  shift amount per requester, sliced like a_in.
REQ-008 gnt  output  NREQ  one-hot grant, one-cycle pulse.
REQ-009 busy  output  1  high while an operation is in flight.
REQ-010 d_out  output  DATAWIDTH  registered shift result.
REQ-011 done  output  NREQ  one-hot completion, one-cycle pulse; d_out is valid in the same cycle.

Function
REQ-012 The FSM SHALL have two states: IDLE and EXEC.
REQ-013 IDLE with req==0 SHALL stay in IDLE with gnt=0 and done=0.
REQ-014 IDLE with req!=0 at edge E0 SHALL select a winner w round-robin, starting from pointer ptr and wrapping modulo NREQ.
REQ-015 At E0 the block SHALL latch a_in[w] and sh_amt_in[w] into operand registers, set gnt<=onehot(w), set busy<=1, and move to EXEC.
REQ-016 At edge E1, with the FSM in EXEC, the block SHALL set d_out<=a_q>>sh_amt_q, done<=onehot(w), gnt<=0, busy<=0, ptr<=(w+1) mod NREQ, and return to IDLE.
REQ-017 Latency SHALL be one cycle from gnt to done; throughput SHALL be at most one operation per two cycles.
REQ-018 A new grant SHALL be issued no earlier than edge E2.
REQ-019 The shift SHALL be logical and zero-filled, using the full DATAWIDTH-bit sh_amt.
REQ-020 Any sh_amt>=DATAWIDTH SHALL yield d_out=0.
REQ-021 Requesters SHALL deassert req in the cycle gnt is seen; req still high after done SHALL count as a new request.
REQ-022 Changes to req, a_in or sh_amt_in during EXEC SHALL NOT affect the operation in flight.
REQ-023 d_out SHALL hold its last value until the next completion.
REQ-024 gnt, done and busy SHALL never be high for more than one cycle per operation.
REQ-025 Pointer wrap: after a grant to requester NREQ-1, ptr SHALL become 0.

Reset
REQ-026 While Rst=1 at a rising edge: state=IDLE, gnt=0, done=0, busy=0, d_out=0, ptr=0, and operand registers=0.
REQ-027 Rst=1 in EXEC SHALL abandon the operation: no done pulse, d_out=0, and ptr=0.
REQ-028 Rst SHALL take priority over all requests; no grant SHALL issue in the reset cycle.

Structure
REQ-029 The state encodings (IDLE=0, EXEC=1) and the default DATAWIDTH/NREQ values SHALL reside in the shared package shr_share_pkg.
REQ-030 The shift SHALL be performed by one instance of the existing SHR datapath module fed by the operand registers; no other sub-module is required.
REQ-031 The round-robin picker SHALL be combinational logic inside shr_share_ctrl.

Verification
REQ-032 Scenario 1: reset, then req=0001 with a=20, sh_amt=1 -> gnt=0001 for one cycle, then done=0001 and d_out=10.
REQ-033 Scenario 2: req=0010 with a=40, sh_amt=4 -> done=0010 and d_out=2.
REQ-034 Scenario 3: req=1111 held with all a=0xFF and sh_amt[i]=i, each req dropped on its gnt -> grants in order 0,1,2,3, two cycles apart; d_out=0xFF, 0x7F, 0x3F, 0x1F.
REQ-035 Scenario 4: sh_amt=8, then sh_amt=200, with a=0xAA -> d_out=0 both times.
REQ-036 Scenario 5: after a grant to requester 2, req=0101 -> requester 0 is granted (ptr=3 wraps to 0).
REQ-037 Scenario 6: Rst=1 during EXEC -> no done, d_out=0, busy=0; the next req=0010 is granted first.
